// File: rtl/pdm_pkg.sv
// Shared constants, sample type and helpers for the PDM microphone decimator.
package pdm_pkg;

   localparam int CLK_HALF_DEF   = 25;
   localparam int DECIM_DEF      = 64;
   localparam int PEAK_DECAY_DEF = 16;

   typedef logic signed [7:0] pcm_t;

   // Magnitude of a sample; the window arithmetic never produces -128.
   function automatic logic [7:0] pcm_abs(input pcm_t v);
      logic [7:0] u;
      u = v;
      return u[7] ? (~u + 8'd1) : u;
   endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider; also flags the clk_i cycle that ends with m_clk falling.
module pdm_clk_gen
   import pdm_pkg::*;
#(
   parameter int CLK_HALF = CLK_HALF_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_m_clk,
   output logic o_fall
);

   localparam int DW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

   logic [DW-1:0] r_div;
   logic          r_m_clk;
   logic          w_wrap;

   assign w_wrap = (r_div == DW'(CLK_HALF - 1));

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div   <= '0;
         r_m_clk <= 1'b0;
      end else if (!i_en) begin
         r_div   <= '0;
         r_m_clk <= 1'b0;
      end else if (w_wrap) begin
         r_div   <= '0;
         r_m_clk <= ~r_m_clk;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign o_m_clk = r_m_clk;
   assign o_fall  = i_en & r_m_clk & w_wrap;

endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: counts ones over DECIM microphone bits per sample.
// Optional decaying peak meter enabled by defining PDM_PEAK_HOLD_EN.
module pdm_decimator
   import pdm_pkg::*;
#(
   parameter int CLK_HALF   = CLK_HALF_DEF,
   parameter int DECIM      = DECIM_DEF,
   parameter int PEAK_DECAY = PEAK_DECAY_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       m_data_i,
   output logic       m_clk_o,
   output logic       m_lrsel_o,
   output logic [7:0] pcm_o,
   output logic [7:0] mag_o,
   output logic       valid_o,
   output logic [7:0] peak_o
);

   localparam int OW = $clog2(DECIM + 1);
   localparam int BW = $clog2(DECIM);

   if (DECIM < 4 || DECIM > 128 || (DECIM & (DECIM - 1)) != 0 || CLK_HALF < 1 || PEAK_DECAY < 1)
   begin : g_bad_param
      $error("pdm_decimator: illegal CLK_HALF, DECIM or PEAK_DECAY");
   end

   logic          w_fall;
   logic          r_sync1;
   logic          r_sync2;
   logic [OW-1:0] r_ones;
   logic [BW-1:0] r_bits;
   logic          r_done;
   pcm_t          r_pcm;
   logic [7:0]    r_mag;
   logic          r_valid;
   logic [8:0]    w_diff;
   pcm_t          w_pcm_next;

   pdm_clk_gen #(.CLK_HALF(CLK_HALF)) u_clk_gen (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_en    (en_i),
      .o_m_clk (m_clk_o),
      .o_fall  (w_fall)
   );

   // m_data_i changes on the microphone's own timing, so it is resynchronized first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= m_data_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_diff     = 9'(r_ones) - 9'(DECIM / 2);
   assign w_pcm_next = pcm_t'(w_diff[7:0]);

   // r_done marks a full window; the sample is published one cycle after its last bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ones  <= '0;
         r_bits  <= '0;
         r_done  <= 1'b0;
         r_pcm   <= '0;
         r_mag   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!en_i) begin
            r_ones <= '0;
            r_bits <= '0;
            r_done <= 1'b0;
         end else if (r_done) begin
            r_pcm   <= w_pcm_next;
            r_mag   <= pcm_abs(w_pcm_next);
            r_valid <= 1'b1;
            r_ones  <= '0;
            r_bits  <= '0;
            r_done  <= 1'b0;
         end else if (w_fall) begin
            r_ones <= r_ones + OW'(r_sync2);
            if (r_bits == BW'(DECIM - 1)) begin
               r_done <= 1'b1;
            end else begin
               r_bits <= r_bits + 1'b1;
            end
         end
      end
   end

   assign m_lrsel_o = 1'b0;
   assign pcm_o     = r_pcm;
   assign mag_o     = r_mag;
   assign valid_o   = r_valid;

`ifdef PDM_PEAK_HOLD_EN
   localparam int DCW = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;

   logic [7:0]     r_peak;
   logic [DCW-1:0] r_decay;

   // A fresh peak restarts the decay interval.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_peak  <= '0;
         r_decay <= '0;
      end else if (r_valid) begin
         if (r_mag > r_peak) begin
            r_peak  <= r_mag;
            r_decay <= '0;
         end else if (r_decay == DCW'(PEAK_DECAY - 1)) begin
            r_decay <= '0;
            if (r_peak != 8'd0) begin
               r_peak <= r_peak - 1'b1;
            end
         end else begin
            r_decay <= r_decay + 1'b1;
         end
      end
   end

   assign peak_o = r_peak;
`else
   assign peak_o = 8'h00;
`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator at default parameters; define
// PDM_PEAK_HOLD_EN for both RTL and bench to exercise the peak meter.
module tb_pdm_decimator;
   import pdm_pkg::*;

   localparam int CLK_HALF = CLK_HALF_DEF;
   localparam int DECIM    = DECIM_DEF;
   localparam int WIN      = 2 * CLK_HALF * DECIM;

   logic       clk_i    = 1'b0;
   logic       rst_ni   = 1'b0;
   logic       en_i     = 1'b0;
   logic       m_data_i = 1'b0;
   logic       m_clk_o;
   logic       m_lrsel_o;
   logic [7:0] pcm_o;
   logic [7:0] mag_o;
   logic       valid_o;
   logic [7:0] peak_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int mode     = 0;
   int alt_cnt  = 0;

   pdm_decimator dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .m_data_i  (m_data_i),
      .m_clk_o   (m_clk_o),
      .m_lrsel_o (m_lrsel_o),
      .pcm_o     (pcm_o),
      .mag_o     (mag_o),
      .valid_o   (valid_o),
      .peak_o    (peak_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural model: counts enabled edges, derives the microphone clock phase,
   // collects bits every 2*CLK_HALF edges and forms a sample from the ones count.
   int         m_n = 0, m_ones = 0, m_bits = 0, m_v = 0, m_dcnt = 0;
   bit         m_pending = 1'b0, m_h0 = 1'b0, m_h1 = 1'b0, m_cap = 1'b0;
   logic       exp_mclk = 1'b0, exp_valid = 1'b0;
   logic [7:0] exp_pcm = 8'h00, exp_mag = 8'h00, exp_peak = 8'h00;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_n = 0; m_ones = 0; m_bits = 0; m_dcnt = 0;
         m_pending = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
         exp_mclk = 1'b0; exp_valid = 1'b0;
         exp_pcm = 8'h00; exp_mag = 8'h00; exp_peak = 8'h00;
      end else begin
`ifdef PDM_PEAK_HOLD_EN
         if (exp_valid) begin
            if (exp_mag > exp_peak) begin
               exp_peak = exp_mag;
               m_dcnt   = 0;
            end else begin
               m_dcnt++;
               if (m_dcnt == PEAK_DECAY_DEF) begin
                  m_dcnt = 0;
                  if (exp_peak > 0) exp_peak = exp_peak - 8'd1;
               end
            end
         end
`endif
         exp_valid = 1'b0;
         m_cap = m_h1;
         m_h1  = m_h0;
         m_h0  = m_data_i;
         if (!en_i) begin
            m_n = 0; m_ones = 0; m_bits = 0; m_pending = 1'b0;
         end else begin
            if (m_pending) begin
               m_v       = m_ones - DECIM / 2;
               exp_pcm   = 8'(m_v);
               exp_mag   = 8'((m_v < 0) ? -m_v : m_v);
               exp_valid = 1'b1;
               m_ones = 0; m_bits = 0; m_pending = 1'b0;
            end
            m_n++;
            if (m_n % (2 * CLK_HALF) == 0) begin
               m_ones += int'(m_cap);
               m_bits++;
               if (m_bits == DECIM) m_pending = 1'b1;
            end
         end
         exp_mclk = en_i && ((m_n % (2 * CLK_HALF)) >= CLK_HALF);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare every output with the model, then advance the data pattern.
   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
      check("m_clk_o", 32'(m_clk_o), 32'(exp_mclk));
      check("m_lrsel_o", 32'(m_lrsel_o), 32'(1'b0));
      check("valid_o", 32'(valid_o), 32'(exp_valid));
      check("pcm_o", 32'(pcm_o), 32'(exp_pcm));
      check("mag_o", 32'(mag_o), 32'(exp_mag));
      check("peak_o", 32'(peak_o), 32'(exp_peak));
      if (mode == 2) begin
         alt_cnt++;
         if (alt_cnt == 2 * CLK_HALF) begin
            alt_cnt  = 0;
            m_data_i = ~m_data_i;
         end
      end
   endtask

   // mode 0: all zeros, 1: all ones, 2: alternating once per microphone clock period.
   task automatic set_mode(input int m);
      mode     = m;
      alt_cnt  = 0;
      m_data_i = (m != 0);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (valid_o) return;
      end
   endtask

   initial begin
      int c0;
      int c1;
      int t_rise;
      int t_fall;
      int t_rise2;
      int n_valid;

      rst_ni = 1'b0;
      en_i   = 1'b0;
      set_mode(0);
      repeat (3) tick();
      check("reset_pcm", 32'(pcm_o), 32'h00);
      check("reset_mag", 32'(mag_o), 32'h00);
      check("reset_valid", 32'(valid_o), 32'h0);
      check("reset_mclk", 32'(m_clk_o), 32'h0);
      check("reset_peak", 32'(peak_o), 32'h00);
      rst_ni = 1'b1;
      repeat (5) tick();

      // Divider timing and constant-ones data.
      set_mode(1);
      en_i    = 1'b1;
      c0      = cyc;
      t_rise  = -1;
      t_fall  = -1;
      t_rise2 = -1;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (t_rise < 0 && m_clk_o) t_rise = cyc - c0;
         else if (t_rise >= 0 && t_fall < 0 && !m_clk_o) t_fall = cyc - c0;
         else if (t_fall >= 0 && t_rise2 < 0 && m_clk_o) t_rise2 = cyc - c0;
      end
      check("first_mclk_rise", 32'(t_rise), 32'd25);
      check("first_capture_fall", 32'(t_fall), 32'd50);
      check("mclk_high_time", 32'(t_fall - t_rise), 32'd25);
      check("mclk_period", 32'(t_rise2 - t_rise), 32'd50);

      wait_valid(WIN + 100);
      check("ones_first_valid_at", 32'(cyc - c0), 32'd3201);
      check("ones_pcm", 32'(pcm_o), 32'h20);
      check("ones_mag", 32'(mag_o), 32'h20);
      c1 = cyc;
      wait_valid(WIN + 100);
      check("ones_valid_spacing", 32'(cyc - c1), 32'd3200);
      check("ones_pcm2", 32'(pcm_o), 32'h20);

      // Drop enable after 30 captures, then restart on all-zero data.
      repeat (30 * 2 * CLK_HALF) tick();
      en_i = 1'b0;
      set_mode(0);
      n_valid = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (valid_o) n_valid++;
      end
      check("no_valid_while_disabled", 32'(n_valid), 32'd0);
      check("mclk_low_disabled", 32'(m_clk_o), 32'h0);
      check("pcm_held_disabled", 32'(pcm_o), 32'h20);
      check("mag_held_disabled", 32'(mag_o), 32'h20);
      en_i = 1'b1;
      c0   = cyc;
      wait_valid(WIN + 100);
      check("zeros_valid_at", 32'(cyc - c0), 32'd3201);
      check("zeros_pcm", 32'(pcm_o), 32'hE0);
      check("zeros_mag", 32'(mag_o), 32'h20);

      // Asynchronous reset in the middle of a ones window.
      set_mode(1);
      repeat (1000) tick();
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_reset_pcm", 32'(pcm_o), 32'h00);
      check("async_reset_mag", 32'(mag_o), 32'h00);
      check("async_reset_valid", 32'(valid_o), 32'h0);
      check("async_reset_mclk", 32'(m_clk_o), 32'h0);
      check("async_reset_peak", 32'(peak_o), 32'h00);
      repeat (2) tick();
      rst_ni = 1'b1;
      c0     = cyc;
      wait_valid(WIN + 100);
      check("post_reset_valid_at", 32'(cyc - c0), 32'd3201);
      check("post_reset_pcm", 32'(pcm_o), 32'h20);

      // Alternating data: silence after one loud sample.
      set_mode(2);
      tick();
`ifdef PDM_PEAK_HOLD_EN
      check("peak_loaded", 32'(peak_o), 32'd32);
`else
      check("peak_tied_zero", 32'(peak_o), 32'h00);
`endif
      wait_valid(WIN + 100);
      check("alt_pcm", 32'(pcm_o), 32'h00);
      check("alt_mag", 32'(mag_o), 32'h00);
      wait_valid(WIN + 100);
      check("alt_pcm2", 32'(pcm_o), 32'h00);
`ifdef PDM_PEAK_HOLD_EN
      for (int k = 3; k <= 15; k++) wait_valid(WIN + 100);
      tick();
      check("peak_before_decay", 32'(peak_o), 32'd32);
      wait_valid(WIN + 100);
      tick();
      check("peak_after_16", 32'(peak_o), 32'd31);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 SHALL have parameter CLK_HALF, default 25, meaning clk_i cycles per m_clk_o half-period (2 MHz at 100 MHz).
REQ-002 SHALL have parameter DECIM, default 64, meaning PDM bits per PCM sample; legal values are powers of 2 in the range 4..128.
REQ-003 SHALL have parameter PEAK_DECAY, default 16, meaning valid samples per 1-LSB peak decay step.
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en_i, input, 1 bit: run enable.
REQ-007 SHALL have port m_data_i, input, 1 bit: microphone PDM data (asynchronous).
REQ-008 SHALL have port m_clk_o, output, 1 bit: microphone clock.
REQ-009 SHALL have port m_lrsel_o, output, 1 bit: channel select.
REQ-010 SHALL have port pcm_o, output, 8 bits: signed two's-complement sample.
REQ-011 SHALL have port mag_o, output, 8 bits: unsigned absolute value of pcm_o.
REQ-012 SHALL have port valid_o, output, 1 bit: one-cycle strobe indicating a new pcm_o/mag_o.
REQ-013 SHALL have port peak_o, output, 8 bits: decaying peak of mag_o.

Function
REQ-014 SHALL toggle m_clk_o each time the divider counts CLK_HALF clk_i cycles while en_i=1.
REQ-015 SHALL hold m_clk_o low and the divider at 0 while en_i=0.
REQ-016 SHALL drive m_lrsel_o constant 0 (left channel; data valid at the m_clk_o rising edge).
REQ-017 SHALL pass m_data_i through a two-flop synchronizer before use.
REQ-018 SHALL capture one PDM bit in the clk_i cycle in which m_clk_o goes 1->0, using the synchronized data.
REQ-019 SHALL keep a ones counter sized to count 0..DECIM inclusive and a bit counter counting 0..DECIM-1.
REQ-020 SHALL, in the cycle after the capture that completes a window (bit counter = DECIM-1), set pcm_o = ones - DECIM/2, set mag_o = |pcm_o|, pulse valid_o for exactly 1 cycle, and clear both counters.
REQ-021 SHALL hold pcm_o and mag_o stable between valid strobes.
REQ-022 SHALL produce these limits for DECIM=64: all ones -> pcm_o=+32 (0x20); all zeros -> pcm_o=-32 (0xE0), mag_o=32.
REQ-023 SHALL produce a sample rate of 100 MHz/(2*CLK_HALF*DECIM), i.e. 31.25 kHz at the defaults.
REQ-024 SHALL, when en_i falls mid-window, discard the partial window: clear the counters and do not pulse valid_o.
REQ-025 SHALL leave pcm_o and mag_o unchanged when en_i falls.
REQ-026 SHALL, when en_i rises, make the first capture occur CLK_HALF*2 clk_i cycles after the rising edge of en_i.
REQ-027 SHALL treat a window-completing capture coinciding with en_i falling as discarded.

Reset
REQ-028 SHALL, while rst_ni=0, force m_clk_o=0, m_lrsel_o=0, pcm_o=0, mag_o=0, valid_o=0, and peak_o=0.
REQ-029 SHALL, while rst_ni=0, clear the divider, both counters, and the synchronizer flops.
REQ-030 SHALL, on reset mid-window, discard the window; the first window after reset release SHALL be complete.

Configuration
REQ-031 SHALL, with PDM_PEAK_HOLD_EN defined, load peak_o with mag_o on each valid strobe where mag_o > peak_o.
REQ-032 SHALL, with PDM_PEAK_HOLD_EN defined, otherwise decrement peak_o by 1 (floor 0) on every PEAK_DECAY-th valid strobe.
REQ-033 SHALL, with PDM_PEAK_HOLD_EN defined, give the load priority over the decay when both fall on the same strobe.
REQ-034 SHALL, without PDM_PEAK_HOLD_EN defined, tie peak_o to 0 and exclude the peak logic from synthesis.

Structure
REQ-035 SHALL place CLK_HALF_DEF, DECIM_DEF, PEAK_DECAY_DEF, and the typedef pcm_t (signed 8-bit) in the shared package pdm_pkg.
REQ-036 SHALL implement the m_clk_o divider and the fall-edge capture strobe as the sub-module pdm_clk_gen.

Verification
REQ-037 SHALL verify: en_i=1, reset released -> m_clk_o period of 50 cycles at 50% duty, and first capture 50 cycles after en_i rises.
REQ-038 SHALL verify: m_data_i=1 constant -> valid_o every 3200 cycles, pcm_o=0x20, mag_o=0x20.
REQ-039 SHALL verify: m_data_i alternating 1,0 per m_clk_o -> pcm_o=0, mag_o=0.
REQ-040 SHALL verify: en_i dropped after 30 captures, then restored with all-zero data -> no valid_o for the partial window, and the next valid_o gives pcm_o=0xE0.
REQ-041 SHALL verify: rst_ni pulsed low mid-window -> all outputs 0 immediately (asynchronously), and the next window is a full 64 bits.
REQ-042 SHALL verify, with PDM_PEAK_HOLD_EN: one sample at mag 32 then silence -> peak_o=32, decrementing to 31 after 16 further valids and to 0 after 512.
